// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared definitions for the packet-atomic AXI-Stream arbiter.
//   arb_state_e : arbiter FSM states (IDLE / PASS / DROP)
//   clog2       : ceiling log2, used for grant index widths
package axis_pkt_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per port
//   last_grant : most recently granted port (lowest priority this round)
//   next_grant : first requesting port searching upward from last_grant+1, mod N
//   any_req    : at least one request is set
module axis_pkt_arbiter_rr_pick
   import axis_pkt_arbiter_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned GW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last_grant,
   output logic [GW-1:0] next_grant,
   output logic          any_req
);

   logic        found;
   int unsigned cand;

   always_comb begin
      next_grant = last_grant;
      any_req    = |req;
      found      = 1'b0;
      cand       = 0;
      // Offsets 1..N visit every port once, ending on last_grant itself.
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(last_grant) + k) % N;
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && (i == cand) && req[i]) begin
               next_grant = GW'(i);
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one 8-bit AXI-Stream path
// between N requesters. A grant is held from the first beat to tlast;
// packets longer than MAX_LEN beats are cut (last forwarded beat carries
// tlast=1, tuser=1) and the rest of the source packet is drained.
//   axis_aclk, axis_areset : clock, synchronous active-high reset
//   s_axis_*               : N slave ports, data port i at [8i+7:8i]
//   m_axis_*               : single master port toward the transmitter
//   grant_id               : current or last granted port
//   trunc_pulse            : one-cycle pulse after a truncated packet
module axis_pkt_arbiter
   import axis_pkt_arbiter_pkg::*;
#(
   parameter int unsigned N       = 2,
   parameter int unsigned MAX_LEN = 1518,
   parameter int unsigned CW      = 11
) (
   input  logic                  axis_aclk,
   input  logic                  axis_areset,
   input  logic [N*8-1:0]        s_axis_tdata,
   input  logic [N-1:0]          s_axis_tuser,
   input  logic [N-1:0]          s_axis_tlast,
   input  logic [N-1:0]          s_axis_tvalid,
   output logic [N-1:0]          s_axis_tready,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [clog2(N)-1:0]   grant_id,
   output logic                  trunc_pulse
);

   localparam int unsigned   GW        = clog2(N);
   localparam logic [CW-1:0] LAST_CNT  = CW'(MAX_LEN - 1);
   localparam logic [CW-1:0] SAT_CNT   = CW'(MAX_LEN);
   localparam logic [GW-1:0] RST_GRANT = GW'(N - 1);

   arb_state_e    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          trunc_q, trunc_d;

   logic [7:0]    sel_data;
   logic          sel_user, sel_last, sel_valid;
   logic [N-1:0]  sel_mask;
   logic [GW-1:0] pick;
   logic          any_req;
   logic          at_limit;

   axis_pkt_arbiter_rr_pick #(
      .N  (N),
      .GW (GW)
   ) u_rr_pick (
      .req        (s_axis_tvalid),
      .last_grant (grant_q),
      .next_grant (pick),
      .any_req    (any_req)
   );

   // Select the granted port's signals; sel_mask is its one-hot position.
   always_comb begin
      sel_data  = '0;
      sel_user  = 1'b0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      sel_mask  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_q == GW'(i)) begin
            sel_data    = s_axis_tdata[i*8 +: 8];
            sel_user    = s_axis_tuser[i];
            sel_last    = s_axis_tlast[i];
            sel_valid   = s_axis_tvalid[i];
            sel_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      beat_cnt_d    = beat_cnt_q;
      trunc_d       = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
      m_axis_tdata  = sel_data;
      m_axis_tuser  = sel_user;
      m_axis_tlast  = sel_last;
      // Last beat we may forward, and the source is not ending here itself.
      at_limit      = (state_q == ST_PASS) && (beat_cnt_q == LAST_CNT) && !sel_last;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d    = pick;
               beat_cnt_d = '0;
               state_d    = ST_PASS;
            end
         end
         ST_PASS: begin
            m_axis_tvalid = sel_valid;
            s_axis_tready = sel_mask & {N{m_axis_tready}};
            if (at_limit) begin
               m_axis_tlast = 1'b1;
               m_axis_tuser = 1'b1;
            end
            if (sel_valid && m_axis_tready) begin
               beat_cnt_d = (beat_cnt_q == SAT_CNT) ? beat_cnt_q : beat_cnt_q + 1'b1;
               if (sel_last) begin
                  state_d = ST_IDLE;
               end else if (at_limit) begin
                  state_d = ST_DROP;
                  trunc_d = 1'b1;
               end
            end
         end
         ST_DROP: begin
            s_axis_tready = sel_mask;
            if (sel_valid && sel_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q    <= ST_IDLE;
         grant_q    <= RST_GRANT;
         beat_cnt_q <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   assign grant_id    = grant_q;
   assign trunc_pulse = trunc_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter (N=3, MAX_LEN=8).
module tb_axis_pkt_arbiter;

   localparam int N       = 3;
   localparam int MAX_LEN = 8;
   localparam int CW      = 4;
   localparam int GW      = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N*8-1:0]   s_tdata = '0;
   logic [N-1:0]     s_tuser = '0, s_tlast = '0, s_tvalid = '0, s_tready;
   logic [7:0]       m_tdata;
   logic             m_tuser, m_tlast, m_tvalid;
   logic             m_tready = 1'b1;
   logic [GW-1:0]    grant_id;
   logic             trunc_pulse;

   always #5 clk = ~clk;

   axis_pkt_arbiter #(
      .N       (N),
      .MAX_LEN (MAX_LEN),
      .CW      (CW)
   ) dut (
      .axis_aclk     (clk),
      .axis_areset   (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tuser  (m_tuser),
      .m_axis_tlast  (m_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .grant_id      (grant_id),
      .trunc_pulse   (trunc_pulse)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- sources: per-port beat queues {user,last,data} ----------
   logic [9:0] srcq [N][$];
   logic [N-1:0] hs_pop = '0;
   logic rst_req  = 1'b1;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: toggle
   int   gap_pct  = 0;

   always @(posedge clk) begin
      #1;
      rst = rst_req;
      for (int i = 0; i < N; i++) begin
         if (hs_pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
         if (srcq[i].size() > 0 && ($urandom_range(99) >= gap_pct)) begin
            s_tvalid[i] = 1'b1;
            {s_tuser[i], s_tlast[i], s_tdata[i*8 +: 8]} = srcq[i][0];
         end else begin
            s_tvalid[i]        = 1'b0;
            s_tlast[i]         = 1'b0;
            s_tuser[i]         = 1'b0;
            s_tdata[i*8 +: 8]  = 8'($urandom);
         end
      end
      case (rdy_mode)
         1:       m_tready = ($urandom_range(3) != 0);
         2:       m_tready = ~m_tready;
         default: m_tready = 1'b1;
      endcase
   end

   // ---------------- behavioural model + per-cycle compare -------------------
   int   m_grant = N - 1;
   bit   m_busy  = 0;   // a packet is being forwarded
   bit   m_drop  = 0;   // discarding the tail of a cut packet
   int   m_sent  = 0;   // beats forwarded for the current packet
   bit   m_pulse = 0;
   bit   chk_en  = 0;

   logic [11:0] out_q[$];       // {grant, user, last, data} per output beat
   int   pulse_cnt = 0;
   int   in_hs[N];
   int   cyc = 0;
   int   sv_cyc = -1, mv_cyc = -1;

   always @(negedge clk) begin
      int g;
      logic [N-1:0] e_ready;
      bit e_valid, e_cap, e_last, e_user, found, nxt_pulse;
      g       = m_grant;
      e_ready = '0;
      e_valid = 0;
      if (m_busy) begin
         e_valid    = s_tvalid[g];
         e_ready[g] = m_tready;
      end else if (m_drop) begin
         e_ready[g] = 1'b1;
      end
      e_cap  = m_busy && (m_sent == MAX_LEN - 1) && !s_tlast[g];
      e_last = s_tlast[g] | e_cap;
      e_user = s_tuser[g] | e_cap;

      if (chk_en) begin
         check("grant_id",    32'(grant_id),    32'(m_grant));
         check("trunc_pulse", 32'(trunc_pulse), 32'(m_pulse));
         check("m_tvalid",    32'(m_tvalid),    32'(e_valid));
         check("s_tready",    32'(s_tready),    32'(e_ready));
         check("m_tdata",     32'(m_tdata),     32'(s_tdata[g*8 +: 8]));
         if (e_valid) begin
            check("m_tlast", 32'(m_tlast), 32'(e_last));
            check("m_tuser", 32'(m_tuser), 32'(e_user));
         end
         if (m_tvalid && m_tready) out_q.push_back({grant_id, m_tuser, m_tlast, m_tdata});
         if (trunc_pulse) pulse_cnt++;
         for (int i = 0; i < N; i++) if (s_tvalid[i] && s_tready[i]) in_hs[i]++;
         if (s_tvalid != '0 && sv_cyc < 0) sv_cyc = cyc;
         if (m_tvalid && mv_cyc < 0) mv_cyc = cyc;
      end
      hs_pop = s_tvalid & s_tready;
      cyc++;

      // advance model to the state after the coming clock edge
      nxt_pulse = 0;
      if (rst) begin
         m_grant = N - 1; m_busy = 0; m_drop = 0; m_sent = 0;
         chk_en  = 1;
      end else if (m_drop) begin
         if (s_tvalid[g] && s_tlast[g]) m_drop = 0;
      end else if (m_busy) begin
         if (s_tvalid[g] && m_tready) begin
            if (s_tlast[g]) m_busy = 0;
            else if (m_sent == MAX_LEN - 1) begin
               m_busy = 0; m_drop = 1; nxt_pulse = 1;
            end
            m_sent = (m_sent + 1 > MAX_LEN) ? MAX_LEN : m_sent + 1;
         end
      end else if (s_tvalid != '0) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && s_tvalid[(g + k) % N]) begin
               m_grant = (g + k) % N;
               found   = 1;
            end
         end
         m_busy = 1;
         m_sent = 0;
      end
      m_pulse = nxt_pulse;
   end

   // ---------------- helpers --------------------------------------------------
   task automatic push_pkt(input int port, input logic [7:0] base, input int len);
      for (int k = 0; k < len; k++)
         srcq[port].push_back({1'b0, (k == len - 1), 8'(base + 8'(k))});
   endtask

   task automatic start_test();
      @(posedge clk);
      rst_req = 1'b1;
      @(posedge clk);
      for (int i = 0; i < N; i++) srcq[i].delete();
      @(posedge clk);
      rst_req = 1'b0;
      out_q.delete();
      pulse_cnt = 0;
      for (int i = 0; i < N; i++) in_hs[i] = 0;
      sv_cyc = -1;
      mv_cyc = -1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((srcq[0].size() + srcq[1].size() + srcq[2].size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_in_time", 32'(n < budget), 32'd1);
      repeat (4) @(posedge clk);
   endtask

   // ---------------- directed + random sequence -------------------------------
   initial begin
      repeat (3) @(posedge clk);
      rst_req = 1'b0;

      // T1: single 4-beat packet on port 0
      start_test();
      push_pkt(0, 8'h11, 4);
      drain(60);
      check("t1_beats", 32'(out_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < out_q.size(); k++) begin
         check("t1_data", 32'(out_q[k][7:0]), 32'h11 + k);
         check("t1_last", 32'(out_q[k][8]), 32'(k == 3));
      end
      check("t1_grant", 32'(grant_id), 32'd0);
      check("t1_latency", 32'(mv_cyc - sv_cyc), 32'd1);

      // T2: ports 0 and 1 with two 3-beat packets each
      start_test();
      push_pkt(0, 8'hA0, 3); push_pkt(0, 8'hA3, 3);
      push_pkt(1, 8'hB0, 3); push_pkt(1, 8'hB3, 3);
      drain(100);
      check("t2_beats", 32'(out_q.size()), 32'd12);
      for (int k = 0; k < 12 && k < out_q.size(); k++) begin
         int pkt, port;
         pkt  = k / 3;
         port = pkt % 2;
         check("t2_port", 32'(out_q[k][11:10]), 32'(port));
         check("t2_data", 32'(out_q[k][7:0]),
               32'((port == 1 ? 8'hB0 : 8'hA0) + 8'((pkt / 2) * 3 + k % 3)));
      end

      // T3: 12-beat packet on port 1 is cut at 8
      start_test();
      push_pkt(1, 8'h40, 12);
      drain(100);
      check("t3_beats", 32'(out_q.size()), 32'd8);
      if (out_q.size() == 8) begin
         check("t3_last_tlast", 32'(out_q[7][8]), 32'd1);
         check("t3_last_tuser", 32'(out_q[7][9]), 32'd1);
         check("t3_b6_tlast",   32'(out_q[6][8]), 32'd0);
         check("t3_b7_data",    32'(out_q[7][7:0]), 32'h47);
      end
      check("t3_pulses", 32'(pulse_cnt), 32'd1);
      check("t3_in_beats", 32'(in_hs[1]), 32'd12);

      // T4: exactly MAX_LEN beats is a normal packet
      start_test();
      push_pkt(0, 8'h50, 8);
      drain(100);
      check("t4_beats", 32'(out_q.size()), 32'd8);
      if (out_q.size() == 8) begin
         check("t4_tlast", 32'(out_q[7][8]), 32'd1);
         check("t4_tuser", 32'(out_q[7][9]), 32'd0);
      end
      check("t4_pulses", 32'(pulse_cnt), 32'd0);

      // T5: toggling m_tready, no beat lost or duplicated
      start_test();
      rdy_mode = 2;
      push_pkt(2, 8'h60, 6);
      drain(100);
      rdy_mode = 0;
      check("t5_beats", 32'(out_q.size()), 32'd6);
      for (int k = 0; k < 6 && k < out_q.size(); k++)
         check("t5_data", 32'(out_q[k][7:0]), 32'h60 + k);

      // T6: reset during beat 3 of a 6-beat packet on port 1
      start_test();
      push_pkt(1, 8'h70, 6);
      begin
         int n;
         n = 0;
         while (out_q.size() < 2 && n < 50) begin
            @(posedge clk);
            n++;
         end
         check("t6_reach_beat3", 32'(n < 50), 32'd1);
      end
      rst_req = 1'b1;
      @(posedge clk);
      srcq[1].delete();
      rst_req = 1'b0;
      @(negedge clk);
      check("t6_ready_after_rst",  32'(s_tready), 32'd0);
      check("t6_valid_after_rst",  32'(m_tvalid), 32'd0);
      @(posedge clk);
      out_q.delete();
      push_pkt(0, 8'h80, 2); push_pkt(1, 8'h90, 2); push_pkt(2, 8'hC0, 2);
      drain(100);
      check("t6_beats", 32'(out_q.size()), 32'd6);
      if (out_q.size() > 0) check("t6_first_port", 32'(out_q[0][11:10]), 32'd0);

      // Random traffic checked cycle-by-cycle against the model
      rdy_mode = 1;
      gap_pct  = 15;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         if ($urandom_range(499) == 0) begin
            rst_req = 1'b1;
            @(posedge clk);
            for (int i = 0; i < N; i++) srcq[i].delete();
            rst_req = 1'b0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (srcq[i].size() < 4 && $urandom_range(5) == 0) begin
                  int len;
                  len = $urandom_range(12, 1);
                  for (int k = 0; k < len; k++)
                     srcq[i].push_back({($urandom_range(7) == 0), (k == len - 1), 8'($urandom)});
               end
            end
         end
      end
      drain(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
